interrupt_controller: RTL and testbench



---
 rtl/interrupt_controller.sv | 153 +++++++++++++++
 tb/tb_interrupt_controller.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// Prioritised interrupt controller: edge-latched, masked requests sequenced into one INT handshake with vector.
// Optional macro IRQ_ROTATE_EN: rotating priority starting after the last serviced id.
module interrupt_controller #(
  parameter int          NUM_IRQ    = 8,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter int          VEC_STRIDE = 4,
  localparam int         IDW        = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  output logic               int_req,
  input  logic               int_ack,
  output logic [31:0]        vector,
  output logic [IDW-1:0]     irq_id,
  input  logic               eoi,
  output logic               busy,
  output logic [NUM_IRQ-1:0] pending
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVICE} state_t;

  state_t               state_q, state_d;
  logic [NUM_IRQ-1:0]   irq_d_q;
  logic [NUM_IRQ-1:0]   pending_q, pending_d;
  logic [NUM_IRQ-1:0]   mask_q, mask_d;
  logic [NUM_IRQ-1:0]   eligible, rise, clr;
  logic                 int_req_q, int_req_d;
  logic                 busy_q, busy_d;
  logic [IDW-1:0]       irq_id_q, irq_id_d;
  logic [31:0]          vector_q, vector_d;
  logic [IDW-1:0]       winner;
  logic                 found;
  logic [31:0]          vec_calc;

  assign rise     = irq & ~irq_d_q;
  assign eligible = pending_q & mask_q;
  assign vec_calc = VEC_BASE + 32'(winner) * 32'(VEC_STRIDE);

`ifdef IRQ_ROTATE_EN
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  // Search starts at the rotation pointer and wraps through all lines.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int off = 0; off < NUM_IRQ; off++) begin
      sum = {1'b0, ptr_q} + (IDW+1)'(off);
      if (sum >= (IDW+1)'(NUM_IRQ)) sum = sum - (IDW+1)'(NUM_IRQ);
      idx = sum[IDW-1:0];
      if (!found && eligible[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end
`else
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (!found && eligible[i]) begin
        winner = IDW'(i);
        found  = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    int_req_d = int_req_q;
    busy_d    = busy_q;
    irq_id_d  = irq_id_q;
    vector_d  = vector_q;
    clr       = '0;
`ifdef IRQ_ROTATE_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          irq_id_d  = winner;
          vector_d  = vec_calc;
          int_req_d = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        // Winner is frozen until accepted; no retargeting.
        if (int_ack) begin
          clr[irq_id_q] = 1'b1;
          int_req_d     = 1'b0;
          busy_d        = 1'b1;
          state_d       = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (eoi) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
`ifdef IRQ_ROTATE_EN
          ptr_d   = (irq_id_q == IDW'(NUM_IRQ-1)) ? '0 : irq_id_q + 1'b1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A fresh edge in the same cycle as the ack keeps the bit pending.
    pending_d = (pending_q & ~clr) | rise;
    mask_d    = mask_we ? mask_wdata : mask_q;
  end

  always_ff @(posedge clk) begin
    irq_d_q <= irq;
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      mask_q    <= '0;
      int_req_q <= 1'b0;
      busy_q    <= 1'b0;
      irq_id_q  <= '0;
      vector_q  <= VEC_BASE;
`ifdef IRQ_ROTATE_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      int_req_q <= int_req_d;
      busy_q    <= busy_d;
      irq_id_q  <= irq_id_d;
      vector_q  <= vector_d;
`ifdef IRQ_ROTATE_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign int_req = int_req_q;
  assign busy    = busy_q;
  assign irq_id  = irq_id_q;
  assign vector  = vector_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed plan steps plus random traffic against a behavioural model.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq;
  logic        mask_we;
  logic [7:0]  mask_wdata;
  logic        int_req;
  logic        int_ack;
  logic [31:0] vector;
  logic [2:0]  irq_id;
  logic        eoi;
  logic        busy;
  logic [7:0]  pending;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model state
  bit [7:0] m_pend, m_mask, m_prev;
  bit       m_req, m_busy;
  int       m_id, m_ptr;

  interrupt_controller #(.NUM_IRQ(8), .VEC_BASE(32'h0000_0100), .VEC_STRIDE(4)) dut (
    .clk(clk), .rst(rst), .irq(irq), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .int_req(int_req), .int_ack(int_ack), .vector(vector), .irq_id(irq_id),
    .eoi(eoi), .busy(busy), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
  endtask

  // First eligible line when scanning upward from 'start' with wrap-around.
  function automatic int pick(input bit [7:0] elig, input int start);
    for (int off = 0; off < 8; off++) begin
      if (elig[(start + off) % 8]) return (start + off) % 8;
    end
    return -1;
  endfunction

  task automatic check_model();
    chk("int_req", 32'(int_req), 32'(m_req));
    chk("busy",    32'(busy),    32'(m_busy));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("irq_id",  32'(irq_id),  32'(m_id));
    chk("vector",  vector,       32'h100 + 32'(m_id) * 4);
  endtask

  // Advance one clock: derive model's next state from current inputs, then compare.
  task automatic tick();
    bit [7:0] n_pend, n_mask, clr;
    bit       n_req, n_busy;
    int       n_id, n_ptr, w;
    n_pend = m_pend; n_mask = m_mask; n_req = m_req; n_busy = m_busy;
    n_id = m_id; n_ptr = m_ptr; clr = 8'h00;
    if (rst) begin
      n_pend = 0; n_mask = 0; n_req = 0; n_busy = 0; n_id = 0; n_ptr = 0;
    end else begin
      if (m_req) begin
        if (int_ack) begin clr[m_id] = 1'b1; n_req = 0; n_busy = 1; end
      end else if (m_busy) begin
        if (eoi) begin
          n_busy = 0;
`ifdef IRQ_ROTATE_EN
          n_ptr = (m_id + 1) % 8;
`endif
        end
      end else begin
        w = pick(m_pend & m_mask, m_ptr);
        if (w >= 0) begin n_id = w; n_req = 1; end
      end
      n_pend = (m_pend & ~clr) | (irq & ~m_prev);
      if (mask_we) n_mask = mask_wdata;
    end
    @(posedge clk);
    #1;
    m_pend = n_pend; m_mask = n_mask; m_req = n_req; m_busy = n_busy;
    m_id = n_id; m_ptr = n_ptr; m_prev = irq;
    check_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; irq = 8'h00; int_ack = 0; eoi = 0; mask_we = 0;
    ticks(2);
    rst = 1'b0;
  endtask

  task automatic set_mask(input bit [7:0] m);
    mask_we = 1'b1; mask_wdata = m; tick();
    mask_we = 1'b0;
  endtask

  task automatic ack_eoi();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq = 8'h00; mask_we = 0; mask_wdata = 8'h00; int_ack = 0; eoi = 0;
    m_pend = 0; m_mask = 0; m_prev = 0; m_req = 0; m_busy = 0; m_id = 0; m_ptr = 0;

    // Reset values
    ticks(2);
    chk("rst_vector", vector, 32'h0000_0100);
    chk("rst_pending", 32'(pending), 32'h0);
    rst = 1'b0;

    // Single request latency and vector
    set_mask(8'hFF);
    irq = 8'h08; tick();
    chk("t1_pending", 32'(pending), 32'h08);
    chk("t1_req_early", 32'(int_req), 32'h0);
    tick();
    chk("t1_req", 32'(int_req), 32'h1);
    chk("t1_id", 32'(irq_id), 32'h3);
    chk("t1_vec", vector, 32'h10C);
    irq = 8'h00;
    ack_eoi();

    // Two simultaneous requests
    do_reset(); set_mask(8'hFF);
    irq = 8'h24; ticks(2);
    chk("t2_id_a", 32'(irq_id), 32'h2);
    chk("t2_vec_a", vector, 32'h108);
    irq = 8'h00;
    ack_eoi(); tick();
    chk("t2_id_b", 32'(irq_id), 32'h5);
    chk("t2_vec_b", vector, 32'h114);
    ack_eoi();

    // Higher-priority edge while requesting does not retarget
    do_reset(); set_mask(8'hFF);
    irq = 8'h10; ticks(2); irq = 8'h00; tick();
    irq = 8'h01; ticks(2);
    chk("t3_req", 32'(int_req), 32'h1);
    chk("t3_id", 32'(irq_id), 32'h4);
    chk("t3_pend0", 32'(pending[0]), 32'h1);
    irq = 8'h00;
    ack_eoi(); tick();
    chk("t3_id_next", 32'(irq_id), 32'h0);
    ack_eoi();

    // Masked line latches but does not request until unmasked
    do_reset(); set_mask(8'hFE);
    irq = 8'h01; ticks(3);
    chk("t4_pending", 32'(pending), 32'h01);
    chk("t4_noreq", 32'(int_req), 32'h0);
    set_mask(8'hFF);
    chk("t4_req_early", 32'(int_req), 32'h0);
    tick();
    chk("t4_req", 32'(int_req), 32'h1);
    irq = 8'h00;
    ack_eoi();

    // New edge coincident with ack keeps the bit pending
    do_reset(); set_mask(8'hFF);
    irq = 8'h02; ticks(2); irq = 8'h00; tick();
    irq = 8'h02; int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("t5_pend1", 32'(pending[1]), 32'h1);
    chk("t5_busy", 32'(busy), 32'h1);
    eoi = 1'b1; tick(); eoi = 1'b0; tick();
    chk("t5_rereq", 32'(int_req), 32'h1);
    chk("t5_id", 32'(irq_id), 32'h1);
    irq = 8'h00;
    ack_eoi();

    // Priority after servicing id 2
    do_reset(); set_mask(8'hFF);
    irq = 8'h04; ticks(2); irq = 8'h00;
    ack_eoi();
    irq = 8'h0A; ticks(2);
`ifdef IRQ_ROTATE_EN
    chk("t6_id", 32'(irq_id), 32'h3);
`else
    chk("t6_id", 32'(irq_id), 32'h1);
`endif
    irq = 8'h00;
    ack_eoi(); ack_eoi();

    // Random traffic against the model
    do_reset(); set_mask(8'hFF);
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 2) == 0) irq = irq ^ (8'h01 << $urandom_range(0, 7));
      int_ack    = m_req  ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      eoi        = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      mask_we    = ($urandom_range(0, 15) == 0);
      mask_wdata = 8'($urandom_range(0, 255));
      rst        = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0; int_ack = 0; eoi = 0; mask_we = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
